// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and a post-reset clear sweep.
// Optional pending-write scoreboard built only when REGFILE_SCOREBOARD_EN is defined.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_WR-1:0]          we,
  input  logic [NUM_WR*ADDR_W-1:0]   waddr,
  input  logic [NUM_WR*DATA_W-1:0]   wdata,
  input  logic [NUM_RD-1:0]          re,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic                       init_done,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic [NUM_RD-1:0]          rd_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  generate
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
      $error("regfile_mp: NUM_RD must be in 1..4");
    end
    if (NUM_WR < 1 || NUM_WR > 2) begin : g_bad_num_wr
      $error("regfile_mp: NUM_WR must be in 1..2");
    end
  endgenerate

  typedef enum logic {CLR, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLR;
      ptr       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        CLR: begin
          mem[ptr] <= '0;
          ptr      <= ptr + ADDR_W'(1);
          if (&ptr) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        default: begin
          // Later ports overwrite earlier ones on an address collision.
          for (int i = 0; i < NUM_WR; i++) begin
            if (we[i] && waddr[i*ADDR_W +: ADDR_W] != '0)
              mem[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
          end
        end
      endcase
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (we[i] && waddr[i*ADDR_W +: ADDR_W] != '0)
          busy[waddr[i*ADDR_W +: ADDR_W]] <= 1'b0;
      end
      // Reservation issued on the same edge as the retiring write must survive.
      if (rsv_en && rsv_addr != '0)
        busy[rsv_addr] <= 1'b1;
    end
  end
`else
  logic unused_rsv;
  assign unused_rsv = ^{rsv_en, rsv_addr};
`endif

  always_comb begin
    rdata   = '0;
    rd_busy = '0;
    for (int j = 0; j < NUM_RD; j++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              hit;
      logic [DATA_W-1:0] byp;
      ra  = raddr[j*ADDR_W +: ADDR_W];
      hit = 1'b0;
      byp = '0;
      for (int i = 0; i < NUM_WR; i++) begin
        if (we[i] && waddr[i*ADDR_W +: ADDR_W] == ra) begin
          hit = 1'b1;
          byp = wdata[i*DATA_W +: DATA_W];
        end
      end
      if (!rst && init_done && re[j] && ra != '0) begin
        rdata[j*DATA_W +: DATA_W] = hit ? byp : mem[ra];
`ifdef REGFILE_SCOREBOARD_EN
        rd_busy[j] = busy[ra] & ~hit;
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear sweep, write/read, bypass priority, read enable, scoreboard, reset.
module tb_regfile_mp;

`ifdef REGFILE_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic        init_done;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [1:0]  rd_busy;

  int checks = 0;
  int errors = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .re        (re),
    .raddr     (raddr),
    .rdata     (rdata),
    .init_done (init_done),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .rd_busy   (rd_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
    rsv_en = 1'b0; rsv_addr = '0;
    tick();
    tick();
    re = 2'b11; raddr = {5'd5, 5'd5};
    #1;
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_rdata0", rdata[31:0], 32'd0);
    chk("rst_rd_busy", {30'd0, rd_busy}, 32'd0);

    // Clear sweep: 31 edges with init_done low, high after the 32nd.
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("sweep_init_done", {31'd0, init_done}, (k == 32) ? 32'd1 : 32'd0);
      if (k < 32) chk("sweep_rdata_x5", rdata[31:0], 32'd0);
      if (k == 10) begin
        we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'hAA};
      end else begin
        we = 2'b00;
      end
    end
    #1;
    chk("x5_lost_write", rdata[31:0], 32'd0);

    // Basic write then read.
    we = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'd0, 32'hDEADBEEF};
    tick();
    we = 2'b00; raddr = {5'd0, 5'd7};
    #1;
    chk("x7_read", rdata[31:0], 32'hDEADBEEF);

    // x0 write is discarded and never bypassed.
    we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'd0, 32'h1234};
    #1;
    chk("x0_no_bypass", rdata[63:32], 32'd0);
    tick();
    we = 2'b00;
    #1;
    chk("x0_after_write", rdata[63:32], 32'd0);

    // Dual-port same-address write: port 1 wins for bypass and storage.
    we = 2'b11; waddr = {5'd9, 5'd9}; wdata = {32'h22, 32'h11};
    raddr = {5'd9, 5'd9};
    #1;
    chk("bypass_prio_p0", rdata[31:0], 32'h22);
    chk("bypass_prio_p1", rdata[63:32], 32'h22);
    tick();
    we = 2'b00;
    #1;
    chk("x9_stored", rdata[31:0], 32'h22);

    // Port-0 write bypassed to read port 1.
    we = 2'b01; waddr = {5'd0, 5'd12}; wdata = {32'd0, 32'h33};
    raddr = {5'd12, 5'd9};
    #1;
    chk("bypass_p0_to_rd1", rdata[63:32], 32'h33);
    chk("rd0_unaffected", rdata[31:0], 32'h22);
    tick();
    we = 2'b00;

    // Read enable gating.
    re = 2'b10; raddr = {5'd12, 5'd7};
    #1;
    chk("re0_low", rdata[31:0], 32'd0);
    chk("x12_stored", rdata[63:32], 32'h33);
    re = 2'b11;
    #1;
    chk("re0_high", rdata[31:0], 32'hDEADBEEF);

    // Scoreboard reservation.
    rsv_en = 1'b1; rsv_addr = 5'd3;
    tick();
    rsv_en = 1'b0; raddr = {5'd7, 5'd3};
    #1;
    chk("busy_x3", {31'd0, rd_busy[0]}, {31'd0, SB});
    chk("busy_x7_clear", {31'd0, rd_busy[1]}, 32'd0);

    // Write x3 while re-reserving x3: bypass hides busy, set wins on the edge.
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'd0, 32'h5};
    rsv_en = 1'b1; rsv_addr = 5'd3;
    #1;
    chk("busy_bypass_hit", {31'd0, rd_busy[0]}, 32'd0);
    tick();
    we = 2'b00; rsv_en = 1'b0;
    #1;
    chk("busy_set_wins", {31'd0, rd_busy[0]}, {31'd0, SB});
    chk("x3_is_5", rdata[31:0], 32'h5);

    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'd0, 32'h6};
    tick();
    we = 2'b00;
    #1;
    chk("busy_cleared", {31'd0, rd_busy[0]}, 32'd0);
    chk("x3_is_6", rdata[31:0], 32'h6);

    rsv_en = 1'b1; rsv_addr = 5'd0;
    tick();
    rsv_en = 1'b0; raddr = {5'd7, 5'd0};
    #1;
    chk("x0_never_busy", {31'd0, rd_busy[0]}, 32'd0);

    // Mid-operation reset with x7 written and x3 busy.
    rsv_en = 1'b1; rsv_addr = 5'd3;
    tick();
    rsv_en = 1'b0; raddr = {5'd7, 5'd3};
    #1;
    chk("busy_x3_again", {31'd0, rd_busy[0]}, {31'd0, SB});
    rst = 1'b1;
    #1;
    chk("rst_gates_rdata", rdata[63:32], 32'd0);
    tick();
    chk("mid_rst_init_done", {31'd0, init_done}, 32'd0);
    chk("mid_rst_rd_busy", {30'd0, rd_busy}, 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) tick();
    chk("resweep_init_done", {31'd0, init_done}, 32'd1);
    chk("x7_cleared", rdata[63:32], 32'd0);
    chk("x3_not_busy", {31'd0, rd_busy[0]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
